// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//
// Framing stage behind a UART receiver. It waits for a sync byte, then reads
// a length byte, that many payload bytes and an 8-bit additive checksum. The
// checksum is the length byte plus every payload byte, modulo 256. A frame
// whose checksum matches is replayed from an internal buffer as a valid/ready
// byte stream. A frame that fails is flagged and thrown away.
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to build an inter-byte
// timeout. If a frame stalls for TIMEOUT_CLKS clocks between bytes, the
// parser flags an error and drops the frame. Without the macro no counter is
// built, and the parser waits for the next byte for as long as it takes.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Rx_DV      one-cycle byte strobe from the receiver
//   i_Rx_Byte    received byte, valid while i_Rx_DV is high
//   o_Out_Valid  o_Out_Byte holds a payload byte of a verified frame
//   o_Out_Byte   payload byte, in arrival order
//   o_Out_Last   marks the final payload byte of the frame
//   i_Out_Ready  consumer accepts the current byte
//   o_Frame_Err  one-cycle pulse: bad length, bad checksum or timeout
//   o_Drop       one-cycle pulse: a byte arrived while output was draining
//   o_Busy       high whenever the parser is not idle
module uart_frame_parser #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int unsigned TIMEOUT_CLKS = 10 * CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Out_Valid,
  output logic [7:0] o_Out_Byte,
  output logic       o_Out_Last,
  input  logic       i_Out_Ready,
  output logic       o_Frame_Err,
  output logic       o_Drop,
  output logic       o_Busy
);

  localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLen = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCheck,
    StOutput
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [IdxW-1:0] rd_idx_nxt;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_last_q, out_last_d;
  logic            frame_err_q, frame_err_d;
  logic            drop_q, drop_d;
  logic            busy_q, busy_d;

  // The payload buffer is not reset; it is only read in StOutput, after the
  // whole frame has been written into it.
  logic [7:0]      buf_q [MAX_LEN];
  logic            buf_we;

  logic            tmo_expire;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_run;

  // States are only entered on a strobe, and every strobe clears the count,
  // so the count also starts from zero on entry to each timed state.
  always_comb begin
    tmo_run    = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);
    tmo_expire = tmo_run && !i_Rx_DV && (tmo_cnt_q == TmoW'(TIMEOUT_CLKS - 1));
    tmo_cnt_d  = '0;
    if (tmo_run && !i_Rx_DV && !tmo_expire) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  assign rd_idx_nxt = rd_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = StLen;
        end
      end

      StLen: begin
        if (i_Rx_DV) begin
          if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MaxLen)) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end else begin
            len_d    = i_Rx_Byte;
            sum_d    = i_Rx_Byte;
            wr_idx_d = '0;
            state_d  = StPayload;
          end
        end
      end

      // A sync byte value here is ordinary payload; there is no resync.
      StPayload: begin
        if (i_Rx_DV) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + i_Rx_Byte;
          wr_idx_d = wr_idx_q + 1'b1;
          if (8'(wr_idx_q) == (len_q - 8'd1)) begin
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == sum_q) begin
            rd_idx_d   = '0;
            out_byte_d = buf_q[0];
            out_last_d = (len_q == 8'd1);
            state_d    = StOutput;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end

      StOutput: begin
        // A byte arriving now cannot be stored, so it is discarded.
        drop_d = i_Rx_DV;
        if (i_Out_Ready) begin
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = StIdle;
          end else begin
            rd_idx_d   = rd_idx_nxt;
            out_byte_d = buf_q[rd_idx_nxt];
            out_last_d = (8'(rd_idx_nxt) == (len_q - 8'd1));
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // tmo_expire already excludes strobe cycles, so a byte in the expiry
    // cycle is processed normally by the case above.
    if (tmo_expire) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
    end

    out_valid_d = (state_d == StOutput);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  always_ff @(posedge i_Clock) begin
    if (buf_we) begin
      buf_q[wr_idx_q] <= i_Rx_Byte;
    end
  end

  assign o_Out_Valid = out_valid_q;
  assign o_Out_Byte  = out_byte_q;
  assign o_Out_Last  = out_last_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Drop      = drop_q;
  assign o_Busy      = busy_q;

endmodule
